fiber_access_16: RTL and testbench

FIBER_ACCESS_16 -- requirements
Module: fiber_access_16

---
 rtl/fiber_access_16.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_fiber_access_16.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fiber_access_16.sv
// fiber_access_16: a compressed-fiber write scanner and read scanner that share
// one external single-port SRAM. Buffet 0 holds the segment array and buffet 1
// holds the coordinate array. The write side fills a tile, then the read side
// walks the fibers selected by incoming positions.
module fiber_access_16 (
  input  logic        clk,
  input  logic        rst_n,                 // active-high despite the name
  input  logic        clk_en,
  input  logic        flush,
  input  logic        tile_en,
  input  logic        buffet_tile_en,
  input  logic        read_scanner_tile_en,
  input  logic        write_scanner_tile_en,
  input  logic [7:0]  buffet_buffet_capacity_log,    // expected 8'h88
  input  logic        write_scanner_compressed,      // expected 1
  input  logic        write_scanner_block_mode,
  input  logic        write_scanner_init_blank,
  input  logic        write_scanner_lowest_level,
  input  logic [15:0] write_scanner_stop_lvl,
  input  logic        read_scanner_block_mode,
  input  logic        read_scanner_dense,
  input  logic        read_scanner_lookup,
  input  logic        read_scanner_root,
  input  logic        read_scanner_spacc_mode,
  input  logic        read_scanner_do_repeat,
  input  logic        read_scanner_repeat_outer_inner_n,
  input  logic [15:0] read_scanner_dim_size,
  input  logic [15:0] read_scanner_inner_dim_offset,
  input  logic [15:0] read_scanner_repeat_factor,
  input  logic [15:0] read_scanner_stop_lvl,
  input  logic [16:0] write_scanner_data_in,
  input  logic        write_scanner_data_in_valid,
  output logic        write_scanner_data_in_ready,
  input  logic [16:0] write_scanner_addr_in,
  input  logic        write_scanner_addr_in_valid,
  output logic        write_scanner_addr_in_ready,
  input  logic [16:0] write_scanner_block_wr_in,
  input  logic        write_scanner_block_wr_in_valid,
  output logic        write_scanner_block_wr_in_ready,
  input  logic [16:0] read_scanner_us_pos_in,
  input  logic        read_scanner_us_pos_in_valid,
  output logic        read_scanner_us_pos_in_ready,
  output logic [16:0] read_scanner_coord_out,
  output logic        read_scanner_coord_out_valid,
  input  logic        read_scanner_coord_out_ready,
  output logic [16:0] read_scanner_pos_out,
  output logic        read_scanner_pos_out_valid,
  input  logic        read_scanner_pos_out_ready,
  output logic [16:0] read_scanner_block_rd_out,
  output logic        read_scanner_block_rd_out_valid,
  input  logic        read_scanner_block_rd_out_ready,
  output logic [8:0]  addr_to_mem,
  output logic [63:0] data_to_mem,
  output logic        wen_to_mem,
  output logic        ren_to_mem,
  input  logic [63:0] data_from_mem
);

  typedef enum logic [1:0] {W_INIT, W_WRITE, W_DONE} wr_state_e;
  typedef enum logic [2:0] {R_WAIT, R_GET, R_SEG0, R_SEG1, R_EMIT, R_STOP} rd_state_e;

  localparam logic [16:0] DONE_TOK = 17'h10100;

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [8:0]  n_q, n_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  p_q, p_d;
  logic [8:0]  ptr_q, ptr_d;
  logic [8:0]  end_q, end_d;
  logic        rd_pend_q, rd_pend_d;
  logic [16:0] coord_q, coord_d;
  logic        coord_vld_q, coord_vld_d;
  logic [16:0] pos_q, pos_d;
  logic        pos_vld_q, pos_vld_d;
  logic        live_q, live_d;

  logic        go, outs_free, tile_done;
  logic        wr_ready, pos_ready, wen, ren;
  logic [8:0]  waddr, raddr;
  logic [63:0] wdata;
  logic        wr_fire, pos_fire, coord_fire, pos_out_fire;
  logic        unused_inputs;

  // live_q holds the bus idle for one cycle after reset/flush, so the INIT
  // segment write can never appear while reset is asserted.
  assign go = clk_en & tile_en & buffet_tile_en & read_scanner_tile_en &
              write_scanner_tile_en & live_q & ~flush;
  assign outs_free = ~coord_vld_q & ~pos_vld_q;

  assign write_scanner_data_in_ready  = wr_ready & go;
  assign read_scanner_us_pos_in_ready = pos_ready & go;
  assign read_scanner_coord_out_valid = coord_vld_q & go;
  assign read_scanner_pos_out_valid   = pos_vld_q & go;
  assign read_scanner_coord_out       = coord_q;
  assign read_scanner_pos_out         = pos_q;
  assign wen_to_mem  = wen & go;
  assign ren_to_mem  = ren & go;
  assign addr_to_mem = ren_to_mem ? raddr : (wen_to_mem ? waddr : '0);
  assign data_to_mem = wen_to_mem ? wdata : '0;

  assign write_scanner_addr_in_ready     = 1'b0;
  assign write_scanner_block_wr_in_ready = 1'b0;
  assign read_scanner_block_rd_out       = '0;
  assign read_scanner_block_rd_out_valid = 1'b0;

  assign wr_fire      = write_scanner_data_in_valid & write_scanner_data_in_ready;
  assign pos_fire     = read_scanner_us_pos_in_valid & read_scanner_us_pos_in_ready;
  assign coord_fire   = read_scanner_coord_out_valid & read_scanner_coord_out_ready;
  assign pos_out_fire = read_scanner_pos_out_valid & read_scanner_pos_out_ready;

  assign unused_inputs = ^{buffet_buffet_capacity_log, write_scanner_compressed,
    write_scanner_block_mode, write_scanner_init_blank, write_scanner_lowest_level,
    write_scanner_stop_lvl, read_scanner_block_mode, read_scanner_dense,
    read_scanner_lookup, read_scanner_root, read_scanner_spacc_mode,
    read_scanner_do_repeat, read_scanner_repeat_outer_inner_n, read_scanner_dim_size,
    read_scanner_inner_dim_offset, read_scanner_repeat_factor, read_scanner_stop_lvl,
    write_scanner_addr_in, write_scanner_addr_in_valid, write_scanner_block_wr_in,
    write_scanner_block_wr_in_valid, read_scanner_block_rd_out_ready,
    data_from_mem[63:16]};

  // Ready and memory-request decode from current state and input tokens.
  always_comb begin
    wr_ready  = 1'b0;
    pos_ready = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    waddr     = '0;
    raddr     = '0;
    wdata     = '0;
    case (wr_state_q)
      W_INIT: wen = 1'b1;
      W_WRITE: begin
        wr_ready = write_scanner_data_in[16] | (n_q != 9'd256);
        if (write_scanner_data_in_valid && wr_ready) begin
          if (!write_scanner_data_in[16]) begin
            wen   = 1'b1;
            waddr = {1'b1, n_q[7:0]};
            wdata = {48'd0, write_scanner_data_in[15:0]};
          end else if (write_scanner_data_in != DONE_TOK) begin
            wen   = 1'b1;
            waddr = {1'b0, k_q + 8'd1};
            wdata = {55'd0, n_q};
          end
        end
      end
      default: ;
    endcase
    case (rd_state_q)
      R_GET: begin
        pos_ready = outs_free;
        if (read_scanner_us_pos_in_valid && outs_free && !read_scanner_us_pos_in[16]) begin
          ren   = 1'b1;
          raddr = {1'b0, read_scanner_us_pos_in[7:0]};
        end
      end
      R_SEG0: begin
        ren   = 1'b1;
        raddr = {1'b0, p_q + 8'd1};
      end
      R_EMIT: begin
        if (!rd_pend_q && outs_free && (ptr_q != end_q)) begin
          ren   = 1'b1;
          raddr = {1'b1, ptr_q[7:0]};
        end
      end
      // Only a stop is consumed here; anything else is left for GET.
      R_STOP: pos_ready = outs_free & read_scanner_us_pos_in[16] &
                          (read_scanner_us_pos_in != DONE_TOK);
      default: ;
    endcase
  end

  // Next-state logic for both FSMs, counters and the output token registers.
  always_comb begin
    wr_state_d  = wr_state_q;
    rd_state_d  = rd_state_q;
    n_d         = n_q;
    k_d         = k_q;
    p_d         = p_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    rd_pend_d   = rd_pend_q;
    coord_d     = coord_q;
    coord_vld_d = coord_vld_q;
    pos_d       = pos_q;
    pos_vld_d   = pos_vld_q;
    live_d      = ~flush;
    tile_done   = 1'b0;
    if (flush) begin
      wr_state_d  = W_INIT;
      rd_state_d  = R_WAIT;
      n_d         = '0;
      k_d         = '0;
      p_d         = '0;
      ptr_d       = '0;
      end_d       = '0;
      rd_pend_d   = 1'b0;
      coord_d     = '0;
      coord_vld_d = 1'b0;
      pos_d       = '0;
      pos_vld_d   = 1'b0;
    end else if (go) begin
      if (coord_fire)   coord_vld_d = 1'b0;
      if (pos_out_fire) pos_vld_d   = 1'b0;
      case (rd_state_q)
        R_WAIT: if (wr_state_q == W_DONE) rd_state_d = R_GET;
        R_GET: begin
          if (pos_fire) begin
            if (!read_scanner_us_pos_in[16]) begin
              p_d        = read_scanner_us_pos_in[7:0];
              rd_state_d = R_SEG0;
            end else begin
              coord_vld_d = 1'b1;
              pos_vld_d   = 1'b1;
              if (read_scanner_us_pos_in == DONE_TOK) begin
                coord_d    = DONE_TOK;
                pos_d      = DONE_TOK;
                tile_done  = 1'b1;
                rd_state_d = R_WAIT;
              end else begin
                coord_d = {1'b1, read_scanner_us_pos_in[15:0] + 16'd1};
                pos_d   = {1'b1, read_scanner_us_pos_in[15:0] + 16'd1};
              end
            end
          end
        end
        R_SEG0: begin
          ptr_d      = data_from_mem[8:0];
          rd_state_d = R_SEG1;
        end
        R_SEG1: begin
          end_d      = data_from_mem[8:0];
          rd_pend_d  = 1'b0;
          rd_state_d = R_EMIT;
        end
        R_EMIT: begin
          if (rd_pend_q) begin
            coord_d     = {1'b0, data_from_mem[15:0]};
            pos_d       = {8'd0, ptr_q};
            coord_vld_d = 1'b1;
            pos_vld_d   = 1'b1;
            ptr_d       = ptr_q + 9'd1;
            rd_pend_d   = 1'b0;
          end else if (outs_free) begin
            if (ptr_q == end_q) rd_state_d = R_STOP;
            else                rd_pend_d  = 1'b1;
          end
        end
        R_STOP: begin
          if (outs_free && read_scanner_us_pos_in_valid) begin
            coord_vld_d = 1'b1;
            pos_vld_d   = 1'b1;
            rd_state_d  = R_GET;
            if (pos_fire) begin
              coord_d = {1'b1, read_scanner_us_pos_in[15:0] + 16'd1};
              pos_d   = {1'b1, read_scanner_us_pos_in[15:0] + 16'd1};
            end else begin
              coord_d = 17'h10000;
              pos_d   = 17'h10000;
            end
          end
        end
        default: rd_state_d = R_WAIT;
      endcase
      case (wr_state_q)
        W_INIT: begin
          n_d        = '0;
          k_d        = '0;
          wr_state_d = W_WRITE;
        end
        W_WRITE: begin
          if (wr_fire) begin
            if (!write_scanner_data_in[16])                 n_d = n_q + 9'd1;
            else if (write_scanner_data_in == DONE_TOK)     wr_state_d = W_DONE;
            else                                            k_d = k_q + 8'd1;
          end
        end
        W_DONE: if (tile_done) wr_state_d = W_INIT;
        default: wr_state_d = W_INIT;
      endcase
    end
  end

  // State registers; clk_en freezes everything except a pending flush.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_state_q  <= W_INIT;
      rd_state_q  <= R_WAIT;
      n_q         <= '0;
      k_q         <= '0;
      p_q         <= '0;
      ptr_q       <= '0;
      end_q       <= '0;
      rd_pend_q   <= 1'b0;
      coord_q     <= '0;
      coord_vld_q <= 1'b0;
      pos_q       <= '0;
      pos_vld_q   <= 1'b0;
      live_q      <= 1'b0;
    end else if (clk_en || flush) begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      p_q         <= p_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      rd_pend_q   <= rd_pend_d;
      coord_q     <= coord_d;
      coord_vld_q <= coord_vld_d;
      pos_q       <= pos_d;
      pos_vld_q   <= pos_vld_d;
      live_q      <= live_d;
    end
  end

endmodule

// File: tb/tb_fiber_access_16.sv
// Directed bench for fiber_access_16 with a behavioural 1-cycle-latency SRAM.
module tb_fiber_access_16;

  localparam logic [16:0] S0 = 17'h10000;
  localparam logic [16:0] S1 = 17'h10001;
  localparam logic [16:0] D  = 17'h10100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clk_en, flush, tile_en, buffet_tile_en, rs_tile_en, ws_tile_en;
  logic [16:0] win, pin;
  logic        win_v, win_r, pin_v, pin_r;
  logic [16:0] coord_out, pos_out, blk_rd;
  logic        coord_v, coord_r, pos_v, pos_r, blk_rd_v;
  logic        addr_in_r, blk_wr_r;
  logic [8:0]  addr;
  logic [63:0] wdata, rdata;
  logic        wen, ren;
  logic [63:0] mem [0:511];

  int n_checks = 0;
  int n_fail = 0;
  int wen_count = 0;
  int both_count = 0;
  int bp_mode = 0;
  logic [16:0] cq[$], pq[$], ec[$], ep[$], ws[$], ps[$];

  fiber_access_16 dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .buffet_tile_en(buffet_tile_en), .read_scanner_tile_en(rs_tile_en),
    .write_scanner_tile_en(ws_tile_en), .buffet_buffet_capacity_log(8'h88),
    .write_scanner_compressed(1'b1), .write_scanner_block_mode(1'b0),
    .write_scanner_init_blank(1'b0), .write_scanner_lowest_level(1'b0),
    .write_scanner_stop_lvl(16'd0), .read_scanner_block_mode(1'b0),
    .read_scanner_dense(1'b0), .read_scanner_lookup(1'b0), .read_scanner_root(1'b0),
    .read_scanner_spacc_mode(1'b0), .read_scanner_do_repeat(1'b0),
    .read_scanner_repeat_outer_inner_n(1'b0), .read_scanner_dim_size(16'd0),
    .read_scanner_inner_dim_offset(16'd0), .read_scanner_repeat_factor(16'd0),
    .read_scanner_stop_lvl(16'd0),
    .write_scanner_data_in(win), .write_scanner_data_in_valid(win_v),
    .write_scanner_data_in_ready(win_r),
    .write_scanner_addr_in(17'd0), .write_scanner_addr_in_valid(1'b0),
    .write_scanner_addr_in_ready(addr_in_r),
    .write_scanner_block_wr_in(17'd0), .write_scanner_block_wr_in_valid(1'b0),
    .write_scanner_block_wr_in_ready(blk_wr_r),
    .read_scanner_us_pos_in(pin), .read_scanner_us_pos_in_valid(pin_v),
    .read_scanner_us_pos_in_ready(pin_r),
    .read_scanner_coord_out(coord_out), .read_scanner_coord_out_valid(coord_v),
    .read_scanner_coord_out_ready(coord_r),
    .read_scanner_pos_out(pos_out), .read_scanner_pos_out_valid(pos_v),
    .read_scanner_pos_out_ready(pos_r),
    .read_scanner_block_rd_out(blk_rd), .read_scanner_block_rd_out_valid(blk_rd_v),
    .read_scanner_block_rd_out_ready(1'b1),
    .addr_to_mem(addr), .data_to_mem(wdata), .wen_to_mem(wen), .ren_to_mem(ren),
    .data_from_mem(rdata)
  );

  always @(posedge clk) begin
    if (wen) mem[addr] <= wdata;
    if (ren) rdata <= mem[addr];
  end

  // Output sink: pick readies at the falling edge, record handshakes just before the rising edge.
  initial begin
    coord_r = 1'b1;
    pos_r   = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0: begin coord_r = 1'b1; pos_r = 1'b1; end
        1: begin coord_r = 1'($urandom_range(0, 1)); pos_r = 1'($urandom_range(0, 1)); end
        default: begin coord_r = 1'b0; pos_r = 1'b0; end
      endcase
      #3;
      if (coord_v && coord_r) cq.push_back(coord_out);
      if (pos_v && pos_r) pq.push_back(pos_out);
      if (wen) wen_count++;
      if (wen && ren) both_count++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ctl"}, 64'({coord_v, pos_v, win_r, pin_r, wen, ren, addr}), 64'd0);
    check({tag, " data"}, 64'({coord_out, pos_out}), 64'd0);
    check({tag, " wdata"}, wdata, 64'd0);
  endtask

  // Entered and left at a falling edge; valid stays up until the handshake.
  task automatic send(input bit to_pos, input logic [16:0] tok, output bit acc);
    acc = 1'b0;
    if (to_pos) begin pin = tok; pin_v = 1'b1; end
    else        begin win = tok; win_v = 1'b1; end
    for (int c = 0; c < 300 && !acc; c++) begin
      #3;
      acc = to_pos ? pin_r : win_r;
      @(negedge clk);
    end
    pin_v = 1'b0;
    win_v = 1'b0;
  endtask

  task automatic send_list(input bit to_pos, input string tag);
    bit acc;
    bit all_ok = 1'b1;
    for (int i = 0; i < (to_pos ? ps.size() : ws.size()); i++) begin
      send(to_pos, to_pos ? ps[i] : ws[i], acc);
      all_ok &= acc;
    end
    check({tag, " all tokens accepted"}, 64'(all_ok), 64'd1);
  endtask

  task automatic read_and_compare(input string tag);
    bit got = 1'b0;
    cq.delete();
    pq.delete();
    send_list(1'b1, {tag, " pos_in"});
    for (int c = 0; c < 500 && !got; c++) begin
      got = (cq.size() >= ec.size()) && (pq.size() >= ep.size());
      if (!got) @(negedge clk);
    end
    check({tag, " outputs arrived"}, 64'(got), 64'd1);
    repeat (10) @(negedge clk);
    check({tag, " coord count"}, 64'(cq.size()), 64'(ec.size()));
    check({tag, " pos count"}, 64'(pq.size()), 64'(ep.size()));
    for (int i = 0; i < ec.size() && i < cq.size(); i++)
      check($sformatf("%s coord[%0d]", tag, i), 64'(cq[i]), 64'(ec[i]));
    for (int i = 0; i < ep.size() && i < pq.size(); i++)
      check($sformatf("%s pos[%0d]", tag, i), 64'(pq[i]), 64'(ep[i]));
  endtask

  initial begin
    bit acc, seen, held;
    int base;
    rst_n = 1'b1; clk_en = 1'b1; flush = 1'b0;
    tile_en = 1'b1; buffet_tile_en = 1'b1; rs_tile_en = 1'b1; ws_tile_en = 1'b1;
    win = '0; win_v = 1'b0; pin = '0; pin_v = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check_idle("reset");
    check("unused streams", 64'({addr_in_r, blk_wr_r, blk_rd_v, blk_rd}), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    wen_count = 0;

    // Tile 1 with a clock-enable freeze while a stop is pending.
    send(1'b0, 17'd5, acc); check("t1 tok 5", 64'(acc), 64'd1);
    send(1'b0, 17'd7, acc); check("t1 tok 7", 64'(acc), 64'd1);
    base = wen_count;
    win = S0; win_v = 1'b1; clk_en = 1'b0; held = 1'b0;
    repeat (5) begin #3; held |= win_r | wen | ren; @(negedge clk); end
    check("freeze no activity", 64'(held), 64'd0);
    check("freeze no writes", 64'(wen_count - base), 64'd0);
    clk_en = 1'b1; win_v = 1'b0;
    ws = '{S0, 17'd2, S0, D};
    send_list(1'b0, "t1 write");
    #3;
    check("t1 ready after done", 64'(win_r), 64'd0);
    @(negedge clk);
    check("t1 write count", 64'(wen_count), 64'd6);
    check("t1 seg0", mem[0], 64'd0);
    check("t1 seg1", mem[1], 64'd2);
    check("t1 seg2", mem[2], 64'd3);
    check("t1 crd0", mem[256], 64'd5);
    check("t1 crd1", mem[257], 64'd7);
    check("t1 crd2", mem[258], 64'd2);

    ps = '{17'd1, 17'd0, S0, D};
    ec = '{17'd2, S0, 17'd5, 17'd7, S1, D};
    ep = '{17'd2, S0, 17'd0, 17'd1, S1, D};
    read_and_compare("t1 read");

    // Tile 2: same data, random independent backpressure on both outputs.
    ws = '{17'd5, 17'd7, S0, 17'd2, S0, D};
    send_list(1'b0, "t2 write");
    bp_mode = 1;
    read_and_compare("t2 read");
    bp_mode = 0;

    // Tile 3: empty leading fiber.
    ws = '{S0, 17'd5, S0, D};
    send_list(1'b0, "t3 write");
    check("t3 seg1", mem[1], 64'd0);
    check("t3 seg2", mem[2], 64'd1);
    check("t3 crd0", mem[256], 64'd5);
    ps = '{17'd0, S0, D};
    ec = '{S1, D};
    ep = '{S1, D};
    read_and_compare("t3 read");

    // Tile 4: reset while a coordinate is being presented.
    ws = '{17'd5, 17'd7, S0, 17'd2, S0, D};
    send_list(1'b0, "t4 write");
    cq.delete(); pq.delete();
    bp_mode = 2;
    send(1'b1, 17'd1, acc); check("t4 pos accepted", 64'(acc), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      #3;
      seen = coord_v & pos_v;
      if (!seen) @(negedge clk);
    end
    check("t4 emit reached", 64'(seen), 64'd1);
    check("t4 held coord/pos", 64'({coord_out, pos_out}), 64'({17'd2, 17'd2}));
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    check_idle("mid-emit reset");
    base = wen_count;
    repeat (2) @(negedge clk);
    check("no writes in reset", 64'(wen_count - base), 64'd0);
    check("no tokens leaked", 64'(cq.size() + pq.size()), 64'd0);
    rst_n = 1'b0;
    bp_mode = 0;
    tile_en = 1'b0; win = 17'd5; win_v = 1'b1; base = wen_count;
    repeat (3) @(negedge clk);
    #3;
    check("tile_en off ready", 64'(win_r), 64'd0);
    check("tile_en off writes", 64'(wen_count - base), 64'd0);
    @(negedge clk);
    tile_en = 1'b1; win_v = 1'b0;
    send_list(1'b0, "t4 rewrite");
    ps = '{17'd1, 17'd0, S0, D};
    ec = '{17'd2, S0, 17'd5, 17'd7, S1, D};
    ep = '{17'd2, S0, 17'd0, 17'd1, S1, D};
    read_and_compare("t4 reread");

    // Tile 5: fill all 256 coordinate slots, then a data token must be held off.
    held = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send(1'b0, 17'(i * 3), acc);
      held &= acc;
    end
    check("t5 fill accepted", 64'(held), 64'd1);
    win = 17'h01234; win_v = 1'b1; held = 1'b0;
    repeat (4) begin #3; held |= win_r; @(negedge clk); end
    check("t5 full holdoff", 64'(held), 64'd0);
    win_v = 1'b0;
    ws = '{S0, D};
    send_list(1'b0, "t5 close");
    check("t5 seg1", mem[1], 64'd256);
    check("t5 crd0", mem[256], 64'd0);
    check("t5 crd255", mem[511], 64'd765);
    check("wen/ren overlap", 64'(both_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
